// File: rtl/wb_arbiter_if.sv
// Wishbone bus bundle shared by the instruction, data and memory sides of wb_arbiter.
interface wishbone #(
    parameter int ADR_W  = 27,
    parameter int DATA_W = 256,
    parameter int SEL_W  = 32
);
    logic              CYC;
    logic              STB;
    logic              WE;
    logic [ADR_W-1:0]  ADR;
    logic [SEL_W-1:0]  SEL;
    logic [DATA_W-1:0] DAT_M;
    logic [DATA_W-1:0] DAT_S;
    logic              ACK;
    logic              RTY;

    modport master (output CYC, STB, WE, ADR, SEL, DAT_M, input DAT_S, ACK, RTY);
    modport slave  (input CYC, STB, WE, ADR, SEL, DAT_M, output DAT_S, ACK, RTY);
endinterface

// File: rtl/wb_arbiter.sv
// Two-to-one round-robin Wishbone arbiter: merges ibus and dbus onto one memory port,
// holding a registered grant for the whole transaction plus one turnaround cycle.
module wb_arbiter #(
    parameter int ADR_W  = 27,
    parameter int DATA_W = 256,
    parameter int SEL_W  = 32
) (
    input  logic    CLK,
    input  logic    RST,
    wishbone.slave  ibus,
    wishbone.slave  dbus,
    wishbone.master mem
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        TURN  = 2'd3
    } st_t;

    st_t  r_st;
    logic r_last;   // 1: dbus won most recently, so the next tie goes to ibus
    logic w_ireq;
    logic w_dreq;
    logic w_term;

    assign w_ireq = ibus.CYC & ibus.STB;
    assign w_dreq = dbus.CYC & dbus.STB;
    assign w_term = mem.ACK | mem.RTY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_st   <= IDLE;
            r_last <= 1'b1;
        end else begin
            case (r_st)
                IDLE: begin
                    if (w_ireq && (!w_dreq || r_last)) begin
                        r_st   <= GNT_I;
                        r_last <= 1'b0;
                    end else if (w_dreq) begin
                        r_st   <= GNT_D;
                        r_last <= 1'b1;
                    end
                end
                GNT_I: begin
                    if (w_term)
                        r_st <= TURN;
                    else if (!ibus.CYC)
                        r_st <= IDLE;
                end
                GNT_D: begin
                    if (w_term)
                        r_st <= TURN;
                    else if (!dbus.CYC)
                        r_st <= IDLE;
                end
                default: r_st <= IDLE;
            endcase
        end
    end

    // Requester fields are muxed, never latched; TURN and IDLE keep the memory port quiet.
    always_comb begin
        mem.CYC     = 1'b0;
        mem.STB     = 1'b0;
        mem.WE      = 1'b0;
        mem.ADR     = {ADR_W{1'b0}};
        mem.SEL     = {SEL_W{1'b0}};
        mem.DAT_M   = {DATA_W{1'b0}};
        ibus.ACK    = 1'b0;
        ibus.RTY    = 1'b0;
        dbus.ACK    = 1'b0;
        dbus.RTY    = 1'b0;
        ibus.DAT_S  = mem.DAT_S;
        dbus.DAT_S  = mem.DAT_S;
        case (r_st)
            GNT_I: begin
                mem.CYC   = ibus.CYC;
                mem.STB   = ibus.STB;
                mem.WE    = ibus.WE;
                mem.ADR   = ibus.ADR;
                mem.SEL   = ibus.SEL;
                mem.DAT_M = ibus.DAT_M;
                ibus.ACK  = mem.ACK;
                ibus.RTY  = mem.RTY;
            end
            GNT_D: begin
                mem.CYC   = dbus.CYC;
                mem.STB   = dbus.STB;
                mem.WE    = dbus.WE;
                mem.ADR   = dbus.ADR;
                mem.SEL   = dbus.SEL;
                mem.DAT_M = dbus.DAT_M;
                dbus.ACK  = mem.ACK;
                dbus.RTY  = mem.RTY;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected grants are queued as requests are raised
// and checked against the memory port when the grant appears.
module tb_wb_arbiter;
    localparam int ADR_W  = 27;
    localparam int DATA_W = 256;
    localparam int SEL_W  = 32;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TURN = 2'd3;

    typedef struct {
        logic              is_d;
        logic [ADR_W-1:0]  adr;
        logic              we;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] dat;
    } txn_t;

    logic CLK = 1'b0;
    logic RST;
    int   n_tests = 0;
    int   n_fail  = 0;
    txn_t sb[$];
    logic [DATA_W-1:0] pat;

    always #5 CLK = ~CLK;

    wishbone #(.ADR_W(ADR_W), .DATA_W(DATA_W), .SEL_W(SEL_W)) ibus (), dbus (), mem ();

    wb_arbiter #(.ADR_W(ADR_W), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .ibus (ibus),
        .dbus (dbus),
        .mem  (mem)
    );

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic req_i(input logic [ADR_W-1:0] a, input logic we, input logic [SEL_W-1:0] s,
                         input logic [DATA_W-1:0] d);
        ibus.CYC = 1'b1; ibus.STB = 1'b1; ibus.WE = we;
        ibus.ADR = a; ibus.SEL = s; ibus.DAT_M = d;
        sb.push_back('{1'b0, a, we, s, d});
    endtask

    task automatic req_d(input logic [ADR_W-1:0] a, input logic we, input logic [SEL_W-1:0] s,
                         input logic [DATA_W-1:0] d);
        dbus.CYC = 1'b1; dbus.STB = 1'b1; dbus.WE = we;
        dbus.ADR = a; dbus.SEL = s; dbus.DAT_M = d;
        sb.push_back('{1'b1, a, we, s, d});
    endtask

    task automatic drop_i();
        ibus.CYC = 1'b0; ibus.STB = 1'b0; ibus.WE = 1'b0;
        ibus.ADR = '0; ibus.SEL = '0; ibus.DAT_M = '0;
    endtask

    task automatic drop_d();
        dbus.CYC = 1'b0; dbus.STB = 1'b0; dbus.WE = 1'b0;
        dbus.ADR = '0; dbus.SEL = '0; dbus.DAT_M = '0;
    endtask

    task automatic expect_grant(input string tag);
        txn_t t;
        chk1({tag, "_cyc"}, mem.CYC & mem.STB, 1'b1);
        chk1({tag, "_sb"}, sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
            t = sb.pop_front();
            chkw({tag, "_adr"}, DATA_W'(mem.ADR), DATA_W'(t.adr));
            chk1({tag, "_we"}, mem.WE, t.we);
            chkw({tag, "_sel"}, DATA_W'(mem.SEL), DATA_W'(t.sel));
            chkw({tag, "_dat"}, mem.DAT_M, t.dat);
        end
    endtask

    initial begin
        RST = 1'b1;
        drop_i();
        drop_d();
        mem.ACK = 1'b0; mem.RTY = 1'b0; mem.DAT_S = '0;
        cyc();
        cyc();
        RST = 1'b0;
        settle();
        chk1("rst_cyc", mem.CYC, 1'b0);
        chkw("rst_st", DATA_W'(dut.r_st), DATA_W'(S_IDLE));

        // 1: single instruction read, ACK four cycles after the grant
        cyc();
        req_i(27'h0000010, 1'b0, '1, '0);
        settle();
        chk1("t1_reg_grant", mem.CYC, 1'b0);
        cyc(); settle();
        expect_grant("t1");
        repeat (3) begin
            cyc(); settle();
            chk1("t1_wait", ibus.ACK, 1'b0);
        end
        cyc();
        pat = {32{8'hA5}};
        mem.ACK = 1'b1; mem.DAT_S = pat;
        settle();
        chk1("t1_iack", ibus.ACK, 1'b1);
        chk1("t1_dack", dbus.ACK, 1'b0);
        chkw("t1_idat", ibus.DAT_S, pat);
        chkw("t1_ddat", dbus.DAT_S, pat);
        cyc();
        mem.ACK = 1'b0;
        drop_i();
        settle();
        chk1("t1_turn_cyc", mem.CYC, 1'b0);
        chkw("t1_turn_st", DATA_W'(dut.r_st), DATA_W'(S_TURN));
        cyc(); settle();
        chkw("t1_idle_st", DATA_W'(dut.r_st), DATA_W'(S_IDLE));

        // 2: simultaneous requests after reset alternate I, D, I, D, I, D
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        req_i(ADR_W'(32'h100), 1'b0, '1, DATA_W'(32'h1100));
        req_d(ADR_W'(32'h201), 1'b0, '1, DATA_W'(32'h2201));
        settle();
        chk1("t2_reg_grant", mem.CYC, 1'b0);
        cyc();
        for (int k = 0; k < 6; k++) begin
            settle();
            expect_grant($sformatf("t2_g%0d", k));
            cyc();
            mem.ACK = 1'b1;
            settle();
            chk1($sformatf("t2_own_ack%0d", k), ((k % 2) != 0) ? dbus.ACK : ibus.ACK, 1'b1);
            chk1($sformatf("t2_stall%0d", k), ((k % 2) != 0) ? ibus.ACK : dbus.ACK, 1'b0);
            cyc();
            mem.ACK = 1'b0;
            if (k + 2 < 6) begin
                if ((k % 2) == 0) req_i(ADR_W'(32'h100 + k + 2), 1'b0, '1, DATA_W'(32'h1100 + k + 2));
                else              req_d(ADR_W'(32'h200 + k + 2), 1'b0, '1, DATA_W'(32'h2200 + k + 2));
            end else begin
                if ((k % 2) == 0) drop_i();
                else              drop_d();
            end
            settle();
            chk1($sformatf("t2_turn%0d", k), mem.CYC, 1'b0);
            cyc(); settle();
            chk1($sformatf("t2_idle%0d", k), mem.CYC, 1'b0);
            cyc();
        end

        // 3: data write, instruction request arriving mid-transaction waits
        pat = {8{32'hDEAD_BEEF}};
        req_d(27'h0002000, 1'b1, 32'h0000_00FF, pat);
        settle();
        cyc(); settle();
        expect_grant("t3_d");
        cyc();
        req_i(27'h0000030, 1'b0, '1, '0);
        settle();
        chk1("t3_i_wait0", ibus.ACK, 1'b0);
        chkw("t3_hold_adr", DATA_W'(mem.ADR), DATA_W'(27'h0002000));
        cyc(); settle();
        chk1("t3_i_wait1", ibus.ACK, 1'b0);
        cyc();
        mem.ACK = 1'b1;
        settle();
        chk1("t3_dack", dbus.ACK, 1'b1);
        chk1("t3_iack_blocked", ibus.ACK, 1'b0);
        cyc();
        mem.ACK = 1'b0;
        drop_d();
        settle();
        chk1("t3_turn_cyc", mem.CYC, 1'b0);
        cyc(); settle();
        chk1("t3_idle_cyc", mem.CYC, 1'b0);
        cyc(); settle();
        expect_grant("t3_i");
        cyc();
        mem.ACK = 1'b1;
        settle();
        chk1("t3_iack", ibus.ACK, 1'b1);
        cyc();
        mem.ACK = 1'b0;
        drop_i();
        cyc();

        // 4: retry on dbus, then the held request is granted again
        req_d(27'h0003000, 1'b0, '1, '0);
        cyc(); settle();
        expect_grant("t4_d");
        cyc();
        mem.RTY = 1'b1;
        settle();
        chk1("t4_drty", dbus.RTY, 1'b1);
        chk1("t4_dack", dbus.ACK, 1'b0);
        chk1("t4_irty", ibus.RTY, 1'b0);
        cyc();
        mem.RTY = 1'b0;
        req_d(27'h0003000, 1'b0, '1, '0);
        settle();
        chk1("t4_rty_pulse", dbus.RTY, 1'b0);
        chkw("t4_turn_st", DATA_W'(dut.r_st), DATA_W'(S_TURN));
        chk1("t4_turn_cyc", mem.CYC, 1'b0);
        cyc(); settle();
        chkw("t4_idle_st", DATA_W'(dut.r_st), DATA_W'(S_IDLE));
        cyc(); settle();
        expect_grant("t4_retry");
        cyc();
        mem.ACK = 1'b1;
        settle();
        chk1("t4_dack2", dbus.ACK, 1'b1);
        cyc();
        mem.ACK = 1'b0;
        drop_d();
        cyc();

        // 5: ibus aborts two cycles into its grant, pending dbus follows
        req_i(27'h0000040, 1'b0, '1, '0);
        cyc(); settle();
        expect_grant("t5_i");
        req_d(27'h0004000, 1'b0, '1, '0);
        cyc(); settle();
        chk1("t5_held", mem.CYC, 1'b1);
        cyc();
        drop_i();
        settle();
        chk1("t5_abort_cyc", mem.CYC, 1'b0);
        chk1("t5_abort_stb", mem.STB, 1'b0);
        cyc(); settle();
        chkw("t5_idle_st", DATA_W'(dut.r_st), DATA_W'(S_IDLE));
        cyc(); settle();
        expect_grant("t5_d");

        // 6: reset while dbus waits on memory; late ACK is dropped
        cyc();
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        drop_d();
        settle();
        chkw("t6_rst_st", DATA_W'(dut.r_st), DATA_W'(S_IDLE));
        chk1("t6_rst_cyc", mem.CYC, 1'b0);
        cyc();
        mem.ACK = 1'b1;
        settle();
        chk1("t6_late_iack", ibus.ACK, 1'b0);
        chk1("t6_late_dack", dbus.ACK, 1'b0);
        cyc();
        mem.ACK = 1'b0;
        req_i(27'h0000050, 1'b0, '1, DATA_W'(32'h5050));
        req_d(27'h0005000, 1'b1, 32'h0000_000F, DATA_W'(32'h6060));
        cyc(); settle();
        expect_grant("t6_tie");
        cyc();
        mem.ACK = 1'b1;
        settle();
        chk1("t6_iack", ibus.ACK, 1'b1);
        chk1("t6_dack", dbus.ACK, 1'b0);
        cyc();
        mem.ACK = 1'b0;
        drop_i();
        cyc();
        cyc(); settle();
        expect_grant("t6_d");
        drop_d();
        chk1("sb_drained", sb.size() == 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
